// File: rtl/alu16_regfile.sv
// Operand register file feeding the 16-bit ALU: registered A/B output stage,
// writeback port and a multi-cycle clear sequencer. Optional macro: ALU16_REGFILE_BYPASS_EN.
module alu16_regfile #(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 8,
  parameter int ADDR_W  = 3,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              clr_req,
  output logic              busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

  state_t              state, next_state;
  logic [ADDR_W-1:0]   cnt, next_cnt;
  logic                clear_en;
  logic                wb_commit;
  logic                accept;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [DATA_W-1:0]   rd_a, rd_b;

  assign busy      = (state == CLEAR);
  assign rd_ready  = !busy && (!op_valid || op_ready);
  assign accept    = rd_valid && rd_ready;
  assign wb_commit = wb_we && !busy && !(ZERO_R0 && (wb_addr == '0));

  // Resolves one read port: hardwired zero, optional same-cycle writeback forwarding, else stored value.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] stored);
    logic [DATA_W-1:0] word;
    word = stored;
`ifdef ALU16_REGFILE_BYPASS_EN
    if (wb_commit && (wb_addr == addr)) word = wb_data;
`endif
    if (ZERO_R0 && (addr == '0)) word = '0;
    return word;
  endfunction

  always_comb begin
    rd_a = read_port(rs1_addr, regs[rs1_addr]);
    rd_b = read_port(rs2_addr, regs[rs2_addr]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    clear_en   = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          next_state = CLEAR;
          next_cnt   = '0;
        end
      end
      CLEAR: begin
        clear_en = 1'b1;
        if (cnt == LAST) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the register array is reset explicitly because reset must zero the whole file;
  // state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (clear_en) begin
      regs[cnt] <= '0;
    end else if (wb_commit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Single skid-less output register: data holds while stalled and after consumption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
    end else if (accept) begin
      op_valid <= 1'b1;
      op_a     <= rd_a;
      op_b     <= rd_b;
    end else if (op_ready) begin
      op_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu16_regfile.sv
// Self-checking bench for alu16_regfile: directed vector table, hand sequences for
// backpressure/bypass/clear/reset-mid-clear, and randomized traffic against an array model.
module tb_alu16_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_valid;
  logic        rd_ready;
  logic [2:0]  rs1_addr, rs2_addr;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a, op_b;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        clr_req;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [8];

`ifdef ALU16_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [8];

  alu16_regfile dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .clr_req  (clr_req),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural read as seen by software: R0 is zero, otherwise the stored value.
  function automatic logic [15:0] arch_read(input logic [2:0] a);
    return (a == 3'd0) ? 16'h0000 : model[a];
  endfunction

  function automatic void model_write(input logic [2:0] a, input logic [15:0] d);
    if (a != 3'd0) model[a] = d;
  endfunction

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_we = 1'b0;
    model_write(a, d);
  endtask

  task automatic do_read(input string name, input logic [2:0] r1, input logic [2:0] r2,
                         input logic [15:0] ea, input logic [15:0] eb);
    rd_valid = 1'b1; rs1_addr = r1; rs2_addr = r2; op_ready = 1'b1;
    check({name, " rd_ready"}, rd_ready, 1);
    step();
    rd_valid = 1'b0;
    check({name, " op_valid"}, op_valid, 1);
    check({name, " op_a"}, op_a, ea);
    check({name, " op_b"}, op_b, eb);
  endtask

  initial begin
    logic        exp_valid;
    logic [15:0] exp_a, exp_b, old6;
    int          n;

    rst_n = 1'b0; rd_valid = 1'b0; rs1_addr = '0; rs2_addr = '0; op_ready = 1'b1;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0; clr_req = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    #12;
    check("reset busy", busy, 0);
    check("reset op_valid", op_valid, 0);
    check("reset op_a", op_a, 0);
    check("reset op_b", op_b, 0);
    check("reset rd_ready", rd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Directed table: writes, reads, R0 handling.
    vecs[0] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd5, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000};
    vecs[2] = '{1'b1, 3'd5, 16'h00FF, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000};
    vecs[3] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd5, 16'h1234, 16'h00FF};
    vecs[4] = '{1'b1, 3'd0, 16'hBEEF, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000};
    vecs[5] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd3, 16'h0000, 16'h1234};
    vecs[6] = '{1'b1, 3'd7, 16'h8001, 1'b1, 3'd5, 3'd5, 16'h00FF, 16'h00FF};
    vecs[7] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 3'd0, 16'h8001, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      wb_we = vecs[i].we; wb_addr = vecs[i].waddr; wb_data = vecs[i].wdata;
      rd_valid = vecs[i].rd; rs1_addr = vecs[i].rs1; rs2_addr = vecs[i].rs2; op_ready = 1'b1;
      step();
      if (vecs[i].we) model_write(vecs[i].waddr, vecs[i].wdata);
      wb_we = 1'b0; rd_valid = 1'b0;
      check($sformatf("vec%0d op_valid", i), op_valid, vecs[i].rd);
      if (vecs[i].rd) begin
        check($sformatf("vec%0d op_a", i), op_a, vecs[i].exp_a);
        check($sformatf("vec%0d op_b", i), op_b, vecs[i].exp_b);
      end
    end
    step();

    // Backpressure: pair held, new reads refused, later write does not disturb the latched pair.
    rd_valid = 1'b1; rs1_addr = 3'd3; rs2_addr = 3'd5; op_ready = 1'b0;
    step();
    check("bp op_valid", op_valid, 1);
    check("bp op_a", op_a, 16'h1234);
    rs1_addr = 3'd7; rs2_addr = 3'd7;
    for (int i = 0; i < 3; i++) begin
      wb_we = (i == 0); wb_addr = 3'd3; wb_data = 16'hAAAA;
      check($sformatf("bp%0d rd_ready", i), rd_ready, 0);
      step();
      if (i == 0) model_write(3'd3, 16'hAAAA);
      check($sformatf("bp%0d op_valid", i), op_valid, 1);
      check($sformatf("bp%0d op_a", i), op_a, 16'h1234);
      check($sformatf("bp%0d op_b", i), op_b, 16'h00FF);
    end
    wb_we = 1'b0; rd_valid = 1'b0; op_ready = 1'b1;
    step();
    check("bp consumed op_valid", op_valid, 0);
    check("bp op_a kept", op_a, 16'h1234);
    do_read("bp reread", 3'd3, 3'd5, 16'hAAAA, 16'h00FF);

    // Same-cycle write and read of R6.
    old6 = arch_read(3'd6);
    wb_we = 1'b1; wb_addr = 3'd6; wb_data = 16'h5A5A;
    rd_valid = 1'b1; rs1_addr = 3'd6; rs2_addr = 3'd6; op_ready = 1'b1;
    step();
    wb_we = 1'b0; rd_valid = 1'b0;
    model_write(3'd6, 16'h5A5A);
    check("byp op_a", op_a, BYPASS ? 16'h5A5A : old6);
    check("byp op_b", op_b, BYPASS ? 16'h5A5A : old6);
    do_read("byp reread", 3'd6, 3'd6, 16'h5A5A, 16'h5A5A);

    // Randomized traffic against the model (no clear).
    exp_valid = 1'b0; exp_a = op_a; exp_b = op_b;
    step();
    for (int c = 0; c < 300; c++) begin
      logic        r_rd, r_we, r_ordy;
      logic [2:0]  r1, r2, wa;
      logic [15:0] wd;
      r_rd = 1'($urandom_range(0, 1)); r_we = 1'($urandom_range(0, 1));
      r_ordy = ($urandom_range(0, 3) != 0);
      r1 = 3'($urandom); r2 = 3'($urandom); wa = 3'($urandom); wd = 16'($urandom);
      rd_valid = r_rd; rs1_addr = r1; rs2_addr = r2; op_ready = r_ordy;
      wb_we = r_we; wb_addr = wa; wb_data = wd;
      #1;
      check("rnd rd_ready", rd_ready, !exp_valid || r_ordy);
      if (r_rd && (!exp_valid || r_ordy)) begin
        exp_valid = 1'b1;
        exp_a = (BYPASS && r_we && wa == r1 && r1 != 0) ? wd : arch_read(r1);
        exp_b = (BYPASS && r_we && wa == r2 && r2 != 0) ? wd : arch_read(r2);
      end else if (r_ordy) begin
        exp_valid = 1'b0;
      end
      if (r_we) model_write(wa, wd);
      step();
      check("rnd op_valid", op_valid, exp_valid);
      check("rnd op_a", op_a, exp_a);
      check("rnd op_b", op_b, exp_b);
    end
    rd_valid = 1'b0; wb_we = 1'b0; op_ready = 1'b1;
    step();

    // Clear sequence: fill, pulse clr_req, count busy, drop mid-clear write.
    for (int i = 1; i < 8; i++) do_write(3'(i), 16'h1000 + 16'(i));
    clr_req = 1'b1;
    #1;
    check("clr pre busy", busy, 0);
    step();
    clr_req = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      wb_we = (n == 5); wb_addr = 3'd2; wb_data = 16'h7777;
      rd_valid = 1'b1; rs1_addr = 3'd1; rs2_addr = 3'd1;
      if (n == 2) clr_req = 1'b1;
      #1;
      check("clr rd_ready", rd_ready, 0);
      step();
      clr_req = 1'b0;
      check("clr no accept", op_valid, 0);
      n++;
    end
    wb_we = 1'b0; rd_valid = 1'b0;
    check("clr busy cycles", n, 8);
    check("clr done busy", busy, 0);
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    for (int i = 0; i < 8; i++) do_read($sformatf("clr R%0d", i), 3'(i), 3'(i), 16'h0, 16'h0);

    // Reset on the 3rd clear cycle while a pair is held.
    do_write(3'd4, 16'h1111);
    rd_valid = 1'b1; rs1_addr = 3'd4; rs2_addr = 3'd4; op_ready = 1'b0;
    step();
    rd_valid = 1'b0;
    check("rmc held op_a", op_a, 16'h1111);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("rmc busy1", busy, 1);
    step();
    step();
    check("rmc busy3", busy, 1);
    check("rmc pair kept", op_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rmc busy", busy, 0);
    check("rmc op_valid", op_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    op_ready = 1'b1;
    step();
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    for (int i = 0; i < 8; i++) do_read($sformatf("rmc R%0d", i), 3'(i), 3'(7 - i), 16'h0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu16_regfile.md
Name: alu16_regfile

Overview:
- Operand register file directly upstream of the 16-bit ALU.
- Holds NREGS general registers and supplies the ALU A/B operands through a registered valid/ready output stage.
- Accepts the ALU Result back as a writeback.
- Provides a multi-cycle clear sequencer so software or the controller can zero the file without reset.

Parameters:
- DATA_W, 16, register and operand width; must match the ALU word.
- NREGS, 8, number of registers; power of two, ≥2.
- ADDR_W, 3, register address width; equals log2(NREGS).
- ZERO_R0, 1, when 1: R0 always reads 0 and writes to R0 are dropped.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_valid  in  1  operand read request
- rd_ready  out  1  read request accepted this cycle
- rs1_addr  in  ADDR_W  source register for operand A
- rs2_addr  in  ADDR_W  source register for operand B
- op_valid  out  1  A/B hold a valid operand pair
- op_ready  in  1  ALU side consumes the pair
- op_a  out  DATA_W  operand A (to ALU A)
- op_b  out  DATA_W  operand B (to ALU B)
- wb_we  in  1  writeback enable
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback data (from ALU Result)
- clr_req  in  1  start clear sequence (pulse or level)
- busy  out  1  clear sequence in progress

Behaviour:
- Async reset (rst_n=0) forces:
  - all registers to 0
  - op_valid=0, op_a=0, op_b=0
  - busy=0, FSM=IDLE, clear counter=0
- Output stage is a single skid-less register:
  - rd_ready = !busy && (!op_valid || op_ready).
  - On rd_valid && rd_ready at edge k: op_a/op_b load the register contents at edge k; op_valid=1 from k+1. Latency is 1 cycle.
  - op_valid && !op_ready: op_a/op_b/op_valid hold stable. A new request is not accepted.
  - op_valid && op_ready && !(rd_valid && rd_ready): op_valid clears; op_a/op_b keep their last value.
  - Back-to-back accepts give one operand pair per cycle with op_ready=1.
- Writeback:
  - wb_we at edge k updates reg[wb_addr] at edge k.
  - A write is independent of the read handshake and is never stalled.
  - ZERO_R0=1: writes to address 0 are ignored; reads of address 0 return 0.
  - Operands already latched in op_a/op_b are not updated by later writebacks.
- Same-cycle read and write of the same address: governed by the optional feature.
- Clear FSM:
  - States IDLE and CLEAR.
  - IDLE→CLEAR when clr_req=1. Counter starts at 0; busy=1 from the next cycle.
  - CLEAR: one register zeroed per cycle at reg[counter], then counter increments.
  - At counter=NREGS-1: zero that register, go to IDLE, busy=0 the next cycle. Clear takes NREGS cycles.
  - In CLEAR, wb_we is ignored (writes dropped) and rd_ready=0.
  - An op_valid pair already held stays valid and can still be consumed.
  - clr_req while in CLEAR is ignored; the sequence does not restart.
  - clr_req and wb_we in the same IDLE cycle: the write takes effect; the clear starts next cycle and later zeroes that register.
- Reset mid-clear: immediate IDLE, all cleared, busy=0.
- Out-of-range addresses cannot occur (NREGS = 2^ADDR_W).

Optional Feature:
- Macro: ALU16_REGFILE_BYPASS_EN
- Defined: if a read is accepted in the same cycle as wb_we to the same nonzero address, op_a/op_b capture wb_data. Bypass still applies for address 0 when ZERO_R0=0.
- Undefined: the same case captures the pre-write register value (old data). The write still commits.

Test Plan:
- Reset, then read rs1=3, rs2=5 → op_valid=1 one cycle after accept; op_a=0x0000, op_b=0x0000; busy=0.
- Write R3=0x1234 and R5=0x00FF on separate cycles, then read (3,5) → op_a=0x1234, op_b=0x00FF. Write R0=0xBEEF, then read (0,3) → op_a=0x0000 (ZERO_R0=1).
- Backpressure:
  - Accept (3,5), hold op_ready=0 for 3 cycles while writing R3=0xAAAA → op_a stays 0x1234 and rd_ready=0 throughout.
  - Set op_ready=1 → pair consumed, op_valid=0 the next cycle.
- Same-cycle write R6=0x5A5A and read (6,6):
  - With BYPASS_EN: op_a=op_b=0x5A5A.
  - Without: op_a=op_b=old value. A re-read then returns 0x5A5A in both builds.
- Fill R1..R7 with nonzero values, pulse clr_req:
  - busy=1 for exactly 8 cycles; rd_ready=0 during that time.
  - wb_we to R2 mid-clear is dropped.
  - Afterwards all reads return 0x0000.
- Start a clear, assert rst_n=0 on its 3rd cycle → busy=0 and op_valid=0 immediately; after release, every register reads 0x0000 and reads are accepted.
